aclk_timegen_multi: RTL and testbench
=====================================

Name: aclk_timegen_multi

Overview:
Parametrised time-base generator for the alarm clock. It derives registered one-cycle `one_sec`, `one_min` and `one_hour` strobes from a free-running clock, and exposes live seconds and minutes counts. A fast-watch mode makes minutes advance once per second. A hold input freezes the time base. It feeds the clock/alarm counters and display logic, and replaces the fixed-ratio single-counter time generator.

Parameters:
CYCLES_PER_SEC, 256, clk cycles per second tick; legal range >= 2
SECS_PER_MIN, 60, second ticks per minute; legal range >= 2
MINS_PER_HOUR, 60, minute events per hour; legal range >= 2
PW, $clog2(CYCLES_PER_SEC), prescaler width (derived, do not override)
SW, $clog2(SECS_PER_MIN), sec_count width (derived)
MW, $clog2(MINS_PER_HOUR), min_count width (derived)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset; clears all state
reset_count  input  1  synchronous clear of all counters and strobes
fast_watch  input  1  1 = one minute event per second tick
hold  input  1  1 = freeze prescaler and counters, no strobes
one_sec  output  1  one-cycle pulse per second tick
one_min  output  1  one-cycle pulse per minute event
one_hour  output  1  one-cycle pulse per hour event
sec_count  output  SW  current second, 0..SECS_PER_MIN-1
min_count  output  MW  current minute, 0..MINS_PER_HOUR-1

Behaviour:
- Reset (async) and reset_count (sync) both clear presc, sec_count, min_count, one_sec, one_min and one_hour to 0. Reset takes effect immediately; reset_count takes effect at the next edge.
- Priority: reset > reset_count > hold > normal counting.
- presc counts 0..CYCLES_PER_SEC-1 and wraps to 0.
- sec_tick (internal) = !hold && presc == CYCLES_PER_SEC-1.
- sec_count increments on sec_tick and wraps from SECS_PER_MIN-1 to 0.
- min_evt (internal):
  - fast_watch=0: sec_tick && sec_count == SECS_PER_MIN-1.
  - fast_watch=1: sec_tick.
- min_count increments on min_evt and wraps from MINS_PER_HOUR-1 to 0.
- hour_evt (internal) = min_evt && min_count == MINS_PER_HOUR-1.
- Strobes are registered:
  - one_sec <= sec_tick; one_min <= min_evt; one_hour <= hour_evt.
  - Latency: 1 cycle after the terminal presc cycle. Each strobe is exactly 1 cycle wide. Otherwise 0.
- sec_count and min_count are registered and update on the same edge the strobe rises.
- In fast_watch mode, sec_count still counts and wraps normally; only the minute source changes.
- Mode switch:
  - fast_watch is sampled every cycle, with no pipeline.
  - Toggling does not clear any counter.
  - A toggle in the same cycle as sec_tick uses the new value.
- Hold:
  - presc, sec_count and min_count keep their values; strobes are 0 while hold=1.
  - If hold drops while presc == CYCLES_PER_SEC-1, sec_tick fires on that first non-hold cycle.
- reset_count coincident with sec_tick, min_evt or hour_evt: the clear wins and no strobe is produced.
- Period in normal mode:
  - one_sec every CYCLES_PER_SEC cycles.
  - one_min every CYCLES_PER_SEC*SECS_PER_MIN cycles.
  - one_hour every CYCLES_PER_SEC*SECS_PER_MIN*MINS_PER_HOUR cycles.
  - No drift at any wrap.
- All outputs are driven from flops; there are no combinational paths from inputs to outputs.

Test Plan:
1. Defaults, reset released at cycle 0. Required: first one_sec at cycle 256; one_sec period 256; first one_min at cycle 15360, coincident with one_sec and sec_count returning to 0; one_min period 15360.
2. CYCLES_PER_SEC=4, SECS_PER_MIN=3, MINS_PER_HOUR=2, normal mode. Required: one_min at cycle 12, 24, ...; one_hour only at cycle 24, coincident with one_min and one_sec; min_count sequence 0,1,0.
3. Same small parameters with fast_watch=1. Required: one_min equals one_sec, every 4 cycles; one_hour every 8 cycles; sec_count still cycles 0,1,2. Deassert fast_watch with sec_count=1 and min_count=1: next one_min comes 2 second-ticks later (sec_count wraps).
4. Small parameters, hold=1 for 10 cycles starting when presc=3. Required: no strobes during hold; counters unchanged; one_sec on the first cycle after hold drops; all later periods shifted by exactly 10 cycles.
5. Small parameters:
   - Assert reset_count on the cycle presc=3 and sec_count=2. Required: no one_sec or one_min; all counts 0; next one_sec 4 cycles after reset_count drops.
   - Assert reset mid-count. Required: outputs 0 immediately, without waiting for a clock edge.
6. Small parameters, 1000 random cycles of fast_watch and hold toggles. Checker model compares strobe timing and counts each cycle. Required: zero mismatches; strobes never wider than 1 cycle.

Source files
------------

// File: rtl/aclk_timegen_multi.sv
// Alarm-clock time base: prescaler plus seconds/minutes counters producing
// registered one-cycle second, minute and hour strobes.
module aclk_timegen_multi #(
   parameter int CYCLES_PER_SEC = 256,
   parameter int SECS_PER_MIN   = 60,
   parameter int MINS_PER_HOUR  = 60,
   parameter int PW = $clog2(CYCLES_PER_SEC),
   parameter int SW = $clog2(SECS_PER_MIN),
   parameter int MW = $clog2(MINS_PER_HOUR)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          reset_count,
   input  logic          fast_watch,
   input  logic          hold,
   output logic          one_sec,
   output logic          one_min,
   output logic          one_hour,
   output logic [SW-1:0] sec_count,
   output logic [MW-1:0] min_count
);

   localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_SEC - 1);
   localparam logic [SW-1:0] SEC_MAX   = SW'(SECS_PER_MIN - 1);
   localparam logic [MW-1:0] MIN_MAX   = MW'(MINS_PER_HOUR - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [SW-1:0] sec_q, sec_d;
   logic [MW-1:0] min_q, min_d;
   logic          one_sec_q, one_sec_d;
   logic          one_min_q, one_min_d;
   logic          one_hour_q, one_hour_d;
   logic          sec_tick, min_evt, hour_evt;

   always_comb begin
      sec_tick   = !hold && (presc_q == PRESC_MAX);
      min_evt    = sec_tick && (fast_watch || (sec_q == SEC_MAX));
      hour_evt   = min_evt && (min_q == MIN_MAX);

      presc_d    = presc_q;
      sec_d      = sec_q;
      min_d      = min_q;
      one_sec_d  = 1'b0;
      one_min_d  = 1'b0;
      one_hour_d = 1'b0;

      // A synchronous clear overrides hold and swallows any coincident strobe.
      if (reset_count) begin
         presc_d = '0;
         sec_d   = '0;
         min_d   = '0;
      end else if (!hold) begin
         presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
         if (sec_tick) begin
            sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + 1'b1;
         end
         if (min_evt) begin
            min_d = (min_q == MIN_MAX) ? '0 : min_q + 1'b1;
         end
         one_sec_d  = sec_tick;
         one_min_d  = min_evt;
         one_hour_d = hour_evt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q    <= '0;
         sec_q      <= '0;
         min_q      <= '0;
         one_sec_q  <= 1'b0;
         one_min_q  <= 1'b0;
         one_hour_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         one_sec_q  <= one_sec_d;
         one_min_q  <= one_min_d;
         one_hour_q <= one_hour_d;
      end
   end

   assign one_sec   = one_sec_q;
   assign one_min   = one_min_q;
   assign one_hour  = one_hour_q;
   assign sec_count = sec_q;
   assign min_count = min_q;

endmodule

// File: tb/tb_aclk_timegen_multi.sv
// Bench for aclk_timegen_multi: a small-parameter instance checked every cycle
// against an elapsed-tick model, plus a default-parameter instance for long periods.
module tb_aclk_timegen_multi;

   localparam int SC  = 4;
   localparam int SS  = 3;
   localparam int SM  = 2;
   localparam int SWS = $clog2(SS);
   localparam int MWS = $clog2(SM);

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reset_count = 1'b0;
   logic fast_watch = 1'b0;
   logic hold = 1'b0;

   logic           one_sec, one_min, one_hour;
   logic [SWS-1:0] sec_count;
   logic [MWS-1:0] min_count;

   logic           d_one_sec, d_one_min, d_one_hour;
   logic [5:0]     d_sec_count, d_min_count;

   int passed = 0;
   int total  = 0;

   // Reference model: counts elapsed second ticks and minute events since the
   // last clear; displayed counts are those totals modulo the wrap values.
   int m_presc, m_secs, m_mins;
   bit m_s, m_m, m_h;
   bit prev_s, prev_m, prev_h;

   typedef struct {
      bit rc, fw, hd;
      bit es, em, eh;
      int esc, emc;
   } vec_t;
   vec_t vecs[12];

   aclk_timegen_multi #(
      .CYCLES_PER_SEC(SC), .SECS_PER_MIN(SS), .MINS_PER_HOUR(SM)
   ) dut (
      .clk(clk), .reset(reset), .reset_count(reset_count),
      .fast_watch(fast_watch), .hold(hold),
      .one_sec(one_sec), .one_min(one_min), .one_hour(one_hour),
      .sec_count(sec_count), .min_count(min_count)
   );

   aclk_timegen_multi dut_def (
      .clk(clk), .reset(reset), .reset_count(1'b0),
      .fast_watch(1'b0), .hold(1'b0),
      .one_sec(d_one_sec), .one_min(d_one_min), .one_hour(d_one_hour),
      .sec_count(d_sec_count), .min_count(d_min_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic modelClear();
      m_presc = 0; m_secs = 0; m_mins = 0;
      m_s = 0; m_m = 0; m_h = 0;
      prev_s = 0; prev_m = 0; prev_h = 0;
   endtask

   task automatic modelStep();
      bit tick;
      if (reset_count) begin
         m_presc = 0; m_secs = 0; m_mins = 0;
         m_s = 0; m_m = 0; m_h = 0;
      end else if (hold) begin
         m_s = 0; m_m = 0; m_h = 0;
      end else begin
         tick = (m_presc == SC - 1);
         m_presc = (m_presc + 1) % SC;
         m_s = tick; m_m = 0; m_h = 0;
         if (tick) begin
            m_secs++;
            if (fast_watch || (m_secs % SS == 0)) begin
               m_mins++;
               m_m = 1;
               m_h = (m_mins % SM == 0);
            end
         end
      end
   endtask

   task automatic checkOutput();
      logic [2+SWS+MWS:0] actv, expv;
      actv = {one_sec, one_min, one_hour, sec_count, min_count};
      expv = {m_s, m_m, m_h, SWS'(m_secs % SS), MWS'(m_mins % SM)};
      check("model", int'(actv), int'(expv));
      if (prev_s) check("sec_width", int'(one_sec), 0);
      if (prev_m) check("min_width", int'(one_min), 0);
      if (prev_h) check("hour_width", int'(one_hour), 0);
      prev_s = one_sec; prev_m = one_min; prev_h = one_hour;
   endtask

   task automatic applyStimulus(input bit rc, input bit fw, input bit hd);
      reset_count = rc;
      fast_watch  = fw;
      hold        = hd;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset();
      reset = 1'b1;
      reset_count = 1'b0; fast_watch = 1'b0; hold = 1'b0;
      @(posedge clk);
      @(negedge clk);
      modelClear();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      vecs = '{
         '{0,0,0, 0,0,0, 0,0}, '{0,0,0, 0,0,0, 0,0}, '{0,0,0, 0,0,0, 0,0},
         '{0,0,0, 1,0,0, 1,0}, '{0,0,0, 0,0,0, 1,0}, '{0,0,0, 0,0,0, 1,0},
         '{0,0,0, 0,0,0, 1,0}, '{0,0,0, 1,0,0, 2,0}, '{0,0,0, 0,0,0, 2,0},
         '{0,0,0, 0,0,0, 2,0}, '{0,0,0, 0,0,0, 2,0}, '{0,0,0, 1,1,0, 0,1}
      };

      // Normal mode from reset, then on to the hour event.
      doReset();
      @(negedge clk);
      check("reset_state", int'({one_sec, one_min, one_hour, sec_count, min_count}), 0);
      doReset();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].rc, vecs[i].fw, vecs[i].hd);
         check($sformatf("vec%0d_strobes", i), int'({one_sec, one_min, one_hour}),
               int'({vecs[i].es, vecs[i].em, vecs[i].eh}));
         check($sformatf("vec%0d_counts", i), int'(sec_count) * 16 + int'(min_count),
               vecs[i].esc * 16 + vecs[i].emc);
      end
      for (int i = 13; i < 24; i++) applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      check("hour_at_24", int'({one_sec, one_min, one_hour, sec_count, min_count}), 7 << 3);

      // Fast watch: minute per second tick, hour every 8 cycles.
      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0);
      check("fast_hour", int'({one_sec, one_min, one_hour}), 7);
      check("fast_counts", int'(sec_count) * 16 + int'(min_count), 2 * 16 + 0);

      // Leaving fast watch at sec=1, min=1: next minute after two more ticks.
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);
      check("fast_pre_switch", int'(sec_count) * 16 + int'(min_count), 1 * 16 + 1);
      n = -1;
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(0, 0, 0);
         if (one_min) begin n = k; break; end
      end
      check("fw_off_min_gap", n, 8);

      // Hold for 10 cycles starting at the terminal prescaler value.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 1);
         check("hold_quiet", int'({one_sec, one_min, one_hour, sec_count, min_count}), 0);
      end
      applyStimulus(0, 0, 0);
      check("hold_release_sec", int'(one_sec), 1);
      n = -1;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(0, 0, 0);
         if (one_sec) begin n = k; break; end
      end
      check("hold_period", n, 4);

      // Synchronous clear coincident with a minute tick.
      doReset();
      for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0);
      check("rc_pre_sc", int'(sec_count), 2);
      applyStimulus(1, 0, 0);
      check("rc_clear", int'({one_sec, one_min, one_hour, sec_count, min_count}), 0);
      n = -1;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(0, 0, 0);
         if (one_sec) begin n = k; break; end
      end
      check("rc_next_sec", n, 4);

      // Asynchronous reset between clock edges.
      doReset();
      for (int i = 0; i < 18; i++) applyStimulus(0, 0, 0);
      check("pre_reset_counts", int'(sec_count) * 16 + int'(min_count), 1 * 16 + 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", int'({one_sec, one_min, one_hour, sec_count, min_count}), 0);
      check("async_reset_def", int'(d_sec_count), 0);
      @(negedge clk);
      modelClear();
      reset = 1'b0;

      // Random mode/hold/clear traffic against the model.
      for (int i = 0; i < 1000; i++) begin
         bit fw_n;
         fw_n = ($urandom_range(0, 7) == 0) ? !fast_watch : fast_watch;
         applyStimulus($urandom_range(0, 63) == 0, fw_n, $urandom_range(0, 3) == 0);
      end

      // Default parameters: second and minute periods over two minutes.
      doReset();
      for (int cyc = 1; cyc <= 2 * 15360; cyc++) begin
         applyStimulus(0, 0, 0);
         check("def_strobes", int'({d_one_sec, d_one_min, d_one_hour}),
               (cyc % 256 == 0) ? ((cyc % 15360 == 0) ? 6 : 4) : 0);
         if (d_one_min) check("def_min_sec0", int'(d_sec_count), 0);
      end
      check("def_min_count", int'(d_min_count), 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
